// File: rtl/wb_spi_frame_bridge.sv
// wb_spi_frame_bridge: Wishbone slave that shifts CPU-written words out as 3-wire SPI frames.
// Define WB_SPI_FRAME_BRIDGE_IRQ_EN to add the o_irq level interrupt (DONE & IE).
module wb_spi_frame_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          MAX_BITS  = 64,
  parameter logic [7:0]  DIV_RESET = 8'd4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        o_reg_csb,
  output logic        o_reg_sclk,
  output logic        o_reg_mosi,
  output logic        o_vec_csb,
  output logic        o_vec_sclk,
  output logic        o_vec_mosi,
  output logic        o_busy
`ifdef WB_SPI_FRAME_BRIDGE_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  localparam logic [6:0] MB = 7'(MAX_BITS);

  state_t state, state_n;

  logic [31:0] data0, data1;
  logic [7:0]  clkdiv, div_l, cnt;
  logic        ovr, badlen, done;
  logic [6:0]  last_len, rem;
  logic        last_tgt, tgt_l;
  logic [MAX_BITS-1:0] sh;

  logic        hit, acc, wr, rd, busy;
  logic        frame, sclk_i, mosi_i;
  logic        phase_end, len_bad, ctrl_ok, go;
  logic [1:0]  a;
  logic [6:0]  len_w;
  logic [31:0] rdata, status;
  logic [63:0] full;
  logic [MAX_BITS-1:0] ld_src;
  logic        unused;

  assign unused = &{1'b0, wbs_adr_i[1:0]};

  assign hit  = wbs_stb_i && wbs_cyc_i &&
                (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc  = hit && !wbs_ack_o;
  assign wr   = acc && wbs_we_i;
  assign rd   = acc && !wbs_we_i;
  assign a    = wbs_adr_i[3:2];
  assign busy = (state != S_IDLE);

  assign len_w   = wbs_dat_i[6:0];
  assign len_bad = (len_w == 7'd0) || (len_w > MB);
  assign ctrl_ok = wr && !busy && (a == 2'd2) &&
                   (wbs_sel_i == 4'hF);
  assign go      = ctrl_ok && wbs_dat_i[31] && !len_bad;

  assign full   = {data1, data0};
  assign ld_src = full[MAX_BITS-1:0];

  assign phase_end = (cnt == div_l);

  assign status = {15'd0, last_tgt, 1'b0, last_len,
                   4'd0, done, badlen, ovr, busy};

  always_comb begin
    rdata = '0;
    unique case (a)
      2'd0: rdata = data0;
      2'd1: rdata = (MAX_BITS > 32) ? data1 : 32'd0;
      2'd2: rdata = status;
      2'd3: rdata = {24'd0, clkdiv};
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (go) state_n = S_SETUP;
      S_SETUP: if (phase_end) state_n = S_HIGH;
      S_HIGH:  if (phase_end) state_n = S_LOW;
      S_LOW:   if (phase_end)
                 state_n = (rem == 7'd0) ? S_GAP : S_HIGH;
      S_GAP:   if (phase_end) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Current bit always sits at the MSB of sh.
  assign frame  = (state == S_SETUP) || (state == S_HIGH) ||
                  (state == S_LOW);
  assign sclk_i = (state == S_HIGH);
  assign mosi_i = frame && sh[MAX_BITS-1];

  assign o_reg_csb  = !(frame && !tgt_l);
  assign o_reg_sclk = sclk_i && !tgt_l;
  assign o_reg_mosi = mosi_i && !tgt_l;
  assign o_vec_csb  = !(frame && tgt_l);
  assign o_vec_sclk = sclk_i && tgt_l;
  assign o_vec_mosi = mosi_i && tgt_l;
  assign o_busy     = busy;

`ifdef WB_SPI_FRAME_BRIDGE_IRQ_EN
  logic ie;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ie <= 1'b0;
    else if (ctrl_ok) ie <= wbs_dat_i[29];
  end

  assign o_irq = done && ie;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      data0     <= '0;
      data1     <= '0;
      clkdiv    <= DIV_RESET;
      div_l     <= '0;
      cnt       <= '0;
      ovr       <= 1'b0;
      badlen    <= 1'b0;
      done      <= 1'b0;
      last_len  <= '0;
      last_tgt  <= 1'b0;
      tgt_l     <= 1'b0;
      rem       <= '0;
      sh        <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : 32'd0;
      state     <= state_n;
      cnt       <= (busy && !phase_end) ? cnt + 8'd1 : 8'd0;

      if (wr && busy) begin
        ovr <= 1'b1;
      end else if (wr) begin
        unique case (a)
          2'd0:
            for (int i = 0; i < 4; i++)
              if (wbs_sel_i[i])
                data0[8*i +: 8] <= wbs_dat_i[8*i +: 8];
          2'd1:
            for (int i = 0; i < 4; i++)
              if (wbs_sel_i[i])
                data1[8*i +: 8] <= wbs_dat_i[8*i +: 8];
          2'd2:
            if (wbs_sel_i == 4'hF) begin
              if (wbs_dat_i[30]) begin
                ovr    <= 1'b0;
                badlen <= 1'b0;
                done   <= 1'b0;
              end
              if (wbs_dat_i[31] && len_bad)
                badlen <= 1'b1;
            end
          2'd3:
            if (wbs_sel_i[0]) clkdiv <= wbs_dat_i[7:0];
        endcase
      end

      if (go) begin
        sh       <= ld_src << (MB - len_w);
        rem      <= len_w;
        div_l    <= clkdiv;
        tgt_l    <= wbs_dat_i[8];
        last_len <= len_w;
        last_tgt <= wbs_dat_i[8];
      end

      // Last bit is held through its LOW phase as hold time.
      if (state == S_HIGH && phase_end) begin
        rem <= rem - 7'd1;
        if (rem > 7'd1) sh <= sh << 1;
      end

      if (state == S_GAP && phase_end) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_spi_frame_bridge.sv
// tb_wb_spi_frame_bridge: randomized scoreboard bench for wb_spi_frame_bridge.
// Register/frame expectations come from a transaction-level model of the bridge.
module tb_wb_spi_frame_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, wcyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic        reg_csb, reg_sclk, reg_mosi;
  logic        vec_csb, vec_sclk, vec_mosi;
  logic        busy;
`ifdef WB_SPI_FRAME_BRIDGE_IRQ_EN
  logic        irq;
`endif

  wb_spi_frame_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (wcyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .o_reg_csb  (reg_csb),
    .o_reg_sclk (reg_sclk),
    .o_reg_mosi (reg_mosi),
    .o_vec_csb  (vec_csb),
    .o_vec_sclk (vec_sclk),
    .o_vec_mosi (vec_mosi),
    .o_busy     (busy)
`ifdef WB_SPI_FRAME_BRIDGE_IRQ_EN
    ,
    .o_irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] got,
                              input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endfunction

  function automatic void fail(input string nm);
    checks++;
    $display("FAIL %s got=none exp=event", nm);
  endfunction

  longint cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // Transaction-level model of the bridge
  logic [31:0] m_d0, m_d1;
  logic [7:0]  m_div;
  logic        m_ovr, m_bad, m_done, m_ie;
  logic [6:0]  m_len;
  logic        m_tgt, m_active;
  longint      m_end;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
  } rsp_t;

  typedef struct {
    bit          tgt;
    int          len;
    logic [63:0] bits;
    int          div;
  } frm_t;

  rsp_t rq[$];
  frm_t fq[$];
  int   bq[$];

  function automatic void m_reset();
    m_d0 = '0; m_d1 = '0; m_div = 8'd4;
    m_ovr = 0; m_bad = 0; m_done = 0; m_ie = 0;
    m_len = '0; m_tgt = 0; m_active = 0; m_end = 0;
  endfunction

  function automatic void settle(input longint b);
    if (m_active && b > m_end) begin
      m_done = 1;
      m_active = 0;
    end
  endfunction

  task automatic wb(input logic [1:0] a, input logic w,
                    input logic [31:0] d, input logic [3:0] s);
    int n;
    longint b;
    rsp_t r;
    int len;
    logic [63:0] msk;
    @(posedge clk); #1;
    stb = 1; wcyc = 1; we = w;
    adr = BASE | 32'({a, 2'b00}); dat = d; sel = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    stb = 0; wcyc = 0; we = 0;
    chk("ack_latency", n, 1);
    if (!ack) return;
    b = cyc_n;
    settle(b);
    r.rd = !w;
    r.exp = '0;
    if (w) begin
      if (m_active) m_ovr = 1;
      else case (a)
        2'd0: for (int i = 0; i < 4; i++)
                if (s[i]) m_d0[8*i +: 8] = d[8*i +: 8];
        2'd1: for (int i = 0; i < 4; i++)
                if (s[i]) m_d1[8*i +: 8] = d[8*i +: 8];
        2'd2: if (s == 4'hF) begin
                m_ie = d[29];
                if (d[30]) begin m_ovr = 0; m_bad = 0; m_done = 0; end
                if (d[31]) begin
                  len = int'(d[6:0]);
                  if (len == 0 || len > 64) m_bad = 1;
                  else begin
                    msk = (len == 64) ? '1 : (64'd1 << len) - 64'd1;
                    m_len = d[6:0];
                    m_tgt = d[8];
                    m_active = 1;
                    m_end = b + (int'(m_div) + 1) * (2 * len + 2);
                    fq.push_back('{d[8], len, {m_d1, m_d0} & msk,
                                   int'(m_div)});
                    bq.push_back((int'(m_div) + 1) * (2 * len + 2));
                  end
                end
              end
        2'd3: if (s[0]) m_div = d[7:0];
      endcase
    end else begin
      case (a)
        2'd0: r.exp = m_d0;
        2'd1: r.exp = m_d1;
        2'd2: r.exp = {15'd0, m_tgt, 1'b0, m_len, 4'd0,
                       m_done, m_bad, m_ovr, m_active};
        2'd3: r.exp = {24'd0, m_div};
      endcase
    end
    rq.push_back(r);
  endtask

  task automatic wait_done();
    while (m_active && cyc_n <= m_end + 1) @(posedge clk);
  endtask

  // Monitors: Wishbone responses, SPI frames, busy span
  bit f_abort = 0, b_abort = 0;
  int ack_bad = 0, dat_bad = 0, idle_bad = 0;
  logic ack_prev = 0, prv_b = 0;
  int brun = 0;
  logic [1:0] pc, ps, pm;
  logic prv_s[2] = '{0, 0};
  logic prv_c[2] = '{1, 1};
  int lowcnt[2] = '{0, 0};
  int nb[2] = '{0, 0};
  int hrun[2] = '{0, 0};
  int hmin[2] = '{1000, 1000};
  int hmax[2] = '{0, 0};
  logic [63:0] got[2] = '{64'd0, 64'd0};
  rsp_t rr;
  frm_t ff;

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (ack_prev) ack_bad++;
      if (rq.size() == 0) fail("unexpected_ack");
      else begin
        rr = rq.pop_front();
        if (rr.rd) chk("read_data", dat_o, rr.exp);
      end
    end else if (dat_o !== 32'd0) dat_bad++;
    ack_prev = (ack === 1'b1);

    if (busy === 1'b1) brun++;
    else if (prv_b) begin
      if (b_abort) b_abort = 0;
      else if (bq.size() == 0) fail("unexpected_busy");
      else chk("busy_cycles", brun, bq.pop_front());
      brun = 0;
    end
    prv_b = (busy === 1'b1);

    pc = {vec_csb, reg_csb};
    ps = {vec_sclk, reg_sclk};
    pm = {vec_mosi, reg_mosi};
    for (int p = 0; p < 2; p++) begin
      if (pc[p] === 1'b1 && (ps[p] !== 1'b0 || pm[p] !== 1'b0))
        idle_bad++;
      if (pc[p] === 1'b0) begin
        lowcnt[p]++;
        if (ps[p] && !prv_s[p]) begin
          got[p] = {got[p][62:0], pm[p]};
          nb[p]++;
        end
        if (ps[p]) hrun[p]++;
        else if (prv_s[p]) begin
          if (hrun[p] < hmin[p]) hmin[p] = hrun[p];
          if (hrun[p] > hmax[p]) hmax[p] = hrun[p];
          hrun[p] = 0;
        end
      end else if (pc[p] === 1'b1 && !prv_c[p]) begin
        if (f_abort) f_abort = 0;
        else if (fq.size() == 0) fail("unexpected_frame");
        else begin
          ff = fq.pop_front();
          chk("frame_port", p, ff.tgt);
          chk("frame_len", nb[p], ff.len);
          chk("frame_bits", got[p], ff.bits);
          chk("csb_low_cycles", lowcnt[p],
              (ff.div + 1) * (2 * ff.len + 1));
          chk("sclk_high_min", hmin[p], ff.div + 1);
          chk("sclk_high_max", hmax[p], ff.div + 1);
        end
        lowcnt[p] = 0; nb[p] = 0; got[p] = '0;
        hrun[p] = 0; hmin[p] = 1000; hmax[p] = 0;
      end
      prv_s[p] = (ps[p] === 1'b1);
      prv_c[p] = (pc[p] !== 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, r, n;
    logic [31:0] ctl;
    rst = 1; stb = 0; wcyc = 0; we = 0;
    sel = '0; adr = '0; dat = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_csb", reg_csb, 1);
    chk("rst_vec_csb", vec_csb, 1);
    chk("rst_sclk_mosi", {reg_sclk, reg_mosi, vec_sclk, vec_mosi}, 0);
    chk("rst_busy_ack", {busy, ack}, 0);
    rst = 0;

    wb(2'd3, 0, 0, 4'hF);
    wb(2'd2, 0, 0, 4'hF);

    // 8-bit frame on the register port at full rate
    wb(2'd3, 1, 32'h0, 4'hF);
    wb(2'd0, 1, 32'h0000_00A5, 4'hF);
    wb(2'd2, 1, 32'h8000_0008, 4'hF);
    wait_done();
    wb(2'd2, 0, 0, 4'hF);

    // 40-bit frame on the vector port, with a write while busy
    wb(2'd3, 1, 32'h2, 4'hF);
    wb(2'd1, 1, 32'h0000_0003, 4'hF);
    wb(2'd0, 1, 32'h8000_0001, 4'hF);
    wb(2'd2, 1, 32'h8000_0128, 4'hF);
    wb(2'd0, 1, 32'hFFFF_FFFF, 4'hF);
    wait_done();
    wb(2'd2, 0, 0, 4'hF);
    wb(2'd0, 0, 0, 4'hF);
    wb(2'd2, 1, 32'h4000_0000, 4'hF);
    wb(2'd2, 0, 0, 4'hF);

    // Bad lengths, and a CTRL write without full byte selects
    wb(2'd2, 1, 32'h8000_0000, 4'hF);
    wb(2'd2, 0, 0, 4'hF);
    wb(2'd2, 1, 32'h4000_0000, 4'hF);
    wb(2'd2, 1, 32'h8000_0041, 4'hF);
    wb(2'd2, 0, 0, 4'hF);
    wb(2'd2, 1, 32'hC000_0008, 4'h7);
    wb(2'd2, 0, 0, 4'hF);

    // Non-matching address gets no ack
    @(posedge clk); #1;
    stb = 1; wcyc = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
    n = 0;
    repeat (4) begin @(posedge clk); #1; if (ack) n++; end
    stb = 0; wcyc = 0;
    chk("no_ack_unmapped", n, 0);

    // Reset during the third HIGH phase
    wb(2'd2, 1, 32'h4000_0000, 4'hF);
    wb(2'd2, 1, 32'h8000_010A, 4'hF);
    n = 0; r = 0;
    while (n < 3 && r < 200) begin
      @(posedge clk); #1; r++;
      if (vec_sclk && !prv_s[1]) n++;
    end
    chk("third_high_seen", n, 3);
    rst = 1;
    f_abort = 1; b_abort = 1;
    if (fq.size() > 0) void'(fq.pop_back());
    if (bq.size() > 0) void'(bq.pop_back());
    @(posedge clk); #1;
    chk("midrst_csb", {reg_csb, vec_csb}, 2'b11);
    chk("midrst_sclk_busy", {vec_sclk, vec_mosi, busy, ack}, 0);
    rst = 0;
    m_reset();

    // Reset coinciding with a request wins
    @(posedge clk); #1;
    rst = 1; stb = 1; wcyc = 1; we = 0; adr = BASE; sel = 4'hF;
    @(posedge clk); #1;
    chk("rst_req_ack0", ack, 0);
    rst = 0; stb = 0; wcyc = 0;
    @(posedge clk); #1;
    chk("rst_req_ack1", ack, 0);
    wb(2'd3, 0, 0, 4'hF);
    wb(2'd2, 0, 0, 4'hF);

    // Randomized frames
    for (int it = 0; it < 25; it++) begin
      wb(2'd3, 1, $urandom, 4'hF);
      wb(2'd3, 1, 32'($urandom_range(0, 3)), 4'h1);
      wb(2'd0, 1, $urandom,
         ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15)));
      wb(2'd1, 1, $urandom,
         ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15)));
      r = $urandom_range(0, 9);
      len = (r == 0) ? ((($urandom_range(0, 1)) != 0) ? 0 :
            $urandom_range(65, 127)) : $urandom_range(1, 64);
      ctl = 32'h8000_0000 | 32'(len) |
            (32'($urandom_range(0, 1)) << 8) |
            (32'($urandom_range(0, 1)) << 29) |
            (32'($urandom_range(0, 1)) << 30);
      wb(2'd2, 1, ctl, 4'hF);
      if ($urandom_range(0, 2) == 0) wb(2'd0, 1, $urandom, 4'hF);
      wait_done();
      wb(2'd2, 0, 0, 4'hF);
`ifdef WB_SPI_FRAME_BRIDGE_IRQ_EN
      chk("irq_level", irq, m_done & m_ie);
`endif
      wb(2'd0, 0, 0, 4'hF);
      wb(2'd1, 0, 0, 4'hF);
      wb(2'd3, 0, 0, 4'hF);
      wb(2'd2, 1, 32'h4000_0000, 4'hF);
`ifdef WB_SPI_FRAME_BRIDGE_IRQ_EN
      @(posedge clk); #1;
      chk("irq_cleared", irq, 0);
`endif
    end

    repeat (4) @(posedge clk);
    #1;
    chk("frames_left", fq.size(), 0);
    chk("busy_left", bq.size(), 0);
    chk("responses_left", rq.size(), 0);
    chk("ack_single_cycle", ack_bad, 0);
    chk("dat_zero_no_ack", dat_bad, 0);
    chk("idle_port_quiet", idle_bad, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_spi_frame_bridge.md
Name: wb_spi_frame_bridge

Overview:
- Wishbone slave on the management SoC bus that serialises CPU-written words into 3-wire SPI frames (csb/sclk/mosi).
- Drives the design's register SPI port (i_reg_*) and vector SPI port (i_vec_*), so firmware can load registers and vectors without bit-banging LA pins.
- Sits in user_project_wrapper, directly upstream of top_ew_algofoogle; its outputs are muxed in front of the LA-sourced SPI inputs.

Parameters:
- BASE_ADDR, 32'h3000_0000, slave base; decode is wbs_adr_i[31:4]==BASE_ADDR[31:4].
- MAX_BITS, 64, maximum frame length (1..64); holding/shift registers are this wide.
- DIV_RESET, 8'd4, reset value of CLKDIV.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data; 0 whenever ack is low.
- o_reg_csb, o_reg_sclk, o_reg_mosi  out  1 each  register SPI port.
- o_vec_csb, o_vec_sclk, o_vec_mosi  out  1 each  vector SPI port.
- o_busy  out  1  frame in progress.

Behaviour:
- Register map (adr[3:2]):
  - 0 DATA0 = bits[31:0].
  - 1 DATA1 = bits[63:32]; reads 0 if MAX_BITS≤32.
  - 2 CTRL (write) / STATUS (read).
  - 3 CLKDIV[7:0].
- DATA and CLKDIV writes honour wbs_sel_i per byte. A CTRL write acts only if sel==4'hF; otherwise it is ignored but still acked.
- Wishbone timing:
  - A request is accepted when stb&cyc&address match and ack is low. ack is high the next cycle for exactly 1 cycle.
  - A non-matching address gets no ack.
  - Back-to-back requests give ack every other cycle.
- CTRL write fields:
  - [6:0] LEN, [8] TGT (0=reg, 1=vec).
  - [30] CLR: clears the sticky OVR, BADLEN and DONE flags.
  - [31] START.
- STATUS read fields: [0] busy, [1] OVR, [2] BADLEN, [3] DONE, [14:8] last LEN, [16] last TGT.
- START handling:
  - START with LEN==0 or LEN>MAX_BITS sets BADLEN; no frame is sent.
  - Any DATA or CTRL write while busy is discarded (acked) and sets OVR. CLKDIV writes while busy are also discarded and set OVR.
  - A valid START copies DATA into the shift register and latches LEN, TGT and DIV. Holding registers stay readable and unchanged.
- FSM: IDLE→SETUP→HIGH⇄LOW→GAP→IDLE. Every phase lasts DIV+1 cycles (phase counter 8 bits).
  - The state leaves IDLE on the edge ending the accept cycle, so busy=1 in the ack cycle.
  - SETUP: csb=0, sclk=0, mosi=bit[LEN-1].
  - HIGH: sclk=1, target samples on the rising edge.
  - LOW: sclk=0 and the bit index decrements.
    - If more bits remain, mosi=next bit, then →HIGH.
    - Else mosi holds and LOW acts as hold time, then →GAP.
  - GAP: csb=1, sclk=0, mosi=0. Then →IDLE, DONE=1, busy=0.
  - Bits go out MSB first: DATA[LEN-1] down to DATA[0].
  - Per frame: csb low for (DIV+1)(2·LEN+1) cycles; busy high for (DIV+1)(2·LEN+2) cycles.
- The non-target port stays idle throughout: csb=1, sclk=0, mosi=0.
- Reset (including mid-frame), applied at the next edge:
  - Both csb=1, sclk=0, mosi=0.
  - busy=0, ack=0, dat_o=0.
  - DATA=0, flags=0, CLKDIV=DIV_RESET, FSM=IDLE.
- A simultaneous reset and request: reset wins, no ack.

Optional Feature:
- Macro WB_SPI_FRAME_BRIDGE_IRQ_EN.
- When defined:
  - Extra port o_irq (out, 1): level, set with DONE, cleared by CLR or reset.
  - CTRL[29] IE gates o_irq; o_irq=DONE&IE.
- When undefined:
  - No o_irq port, and CTRL[29] is ignored.
  - DONE is still polled via STATUS.

Test Plan:
- Reset, then read CLKDIV and STATUS → ack 1 cycle after request; CLKDIV=0x04; STATUS=0. Both ports csb=1, sclk=0, mosi=0.
- CLKDIV=0, DATA0=0x000000A5, CTRL=0x80000008 → reg port sends 1,0,1,0,0,1,0,1 on 8 rising sclk edges. csb low 17 cycles, busy 18 cycles, vec port idle, DONE=1.
- CLKDIV=2, DATA1=0x00000003, DATA0=0x80000001, LEN=40, TGT=1 → vec port shifts 0x0380000001 MSB first. Each sclk high lasts 3 cycles; csb low 243 cycles.
- Write DATA0 while busy → ack; OVR=1; frame contents unchanged. CTRL=0x40000000 → OVR=0.
- START with LEN=0 → BADLEN=1, no csb activity. With LEN=65 and MAX_BITS=64 → same result.
- Assert wb_rst_i during the 3rd HIGH phase → next cycle csb=1, sclk=0, busy=0. With IRQ_EN and IE=1, o_irq=1 after a normal frame and 0 after CLR.
